// File: rtl/mem_stage_if.sv
// Data-SRAM request/address-ok/data-ok bus between the memory stage and
// the data cache or SRAM.
interface mem_stage_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_wstrb,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_wstrb,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store at a time on the data-SRAM bus,
// aligns load data and registers the result into the MEM->WB register.
module mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         WB_allowin,
  input  logic [144:0] EX_to_MEM_zip,
  input  logic [81:0]  EX_except_reg,
  output logic         MEM_allowin,
  output logic         front_valid,
  output logic [4:0]   front_addr,
  output logic [31:0]  front_data,
  mem_stage_if.master  dbus,
  output logic [102:0] MEM_to_WB_reg,
  output logic [81:0]  MEM_except_reg
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state;
  state_t state_n;

  logic        valid;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ld_b;
  logic        ld_bu;
  logic        ld_h;
  logic        ld_hu;
  logic        ld_w;
  logic        st_b;
  logic        st_h;
  logic        st_w;
  logic        mem_we;
  logic        res_from_mem;
  logic        gr_we;
  logic [31:0] rkd;
  logic [4:0]  waddr;
  logic [31:0] alu;

  assign valid        = EX_to_MEM_zip[144];
  assign pc           = EX_to_MEM_zip[143:112];
  assign ir           = EX_to_MEM_zip[111:80];
  assign ld_b         = EX_to_MEM_zip[79];
  assign ld_bu        = EX_to_MEM_zip[78];
  assign ld_h         = EX_to_MEM_zip[77];
  assign ld_hu        = EX_to_MEM_zip[76];
  assign ld_w         = EX_to_MEM_zip[75];
  assign st_b         = EX_to_MEM_zip[74];
  assign st_h         = EX_to_MEM_zip[73];
  assign st_w         = EX_to_MEM_zip[72];
  assign mem_we       = EX_to_MEM_zip[71];
  assign res_from_mem = EX_to_MEM_zip[70];
  assign gr_we        = EX_to_MEM_zip[69];
  assign rkd          = EX_to_MEM_zip[68:37];
  assign waddr        = EX_to_MEM_zip[36:32];
  assign alu          = EX_to_MEM_zip[31:0];

  logic        mem_op;
  logic        req;
  logic        readygo;
  logic [31:0] rdata_q;
  logic [31:0] lane;
  logic [15:0] half;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  assign mem_op = ld_b | ld_bu | ld_h | ld_hu | ld_w
                | st_b | st_h | st_w;

  // Gated by rst so the bus stays quiet while held in reset.
  assign req = rst & valid & mem_op & (state == IDLE);

  assign readygo     = valid & (~mem_op | (state == DONE));
  assign MEM_allowin = ~valid | (readygo & WB_allowin);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state <= state_n;
      if (state == WAIT && dbus.data_sram_data_ok)
        rdata_q <= dbus.data_sram_rdata;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req && dbus.data_sram_addr_ok) state_n = WAIT;
      WAIT: if (dbus.data_sram_data_ok) state_n = DONE;
      DONE: if (WB_allowin) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    size  = 2'd0;
    wstrb = 4'b0000;
    wdata = rkd;
    unique case (1'b1)
      st_b: begin
        wdata = {4{rkd[7:0]}};
        wstrb = 4'b0001 << alu[1:0];
      end
      st_h: begin
        size  = 2'd1;
        wdata = {2{rkd[15:0]}};
        wstrb = alu[1] ? 4'b1100 : 4'b0011;
      end
      st_w: begin
        size  = 2'd2;
        wstrb = 4'b1111;
      end
      ld_h, ld_hu: size = 2'd1;
      ld_w:        size = 2'd2;
      default: ;
    endcase
  end

  assign dbus.data_sram_req   = req;
  assign dbus.data_sram_wr    = mem_we;
  assign dbus.data_sram_size  = size;
  assign dbus.data_sram_wstrb = wstrb;
  assign dbus.data_sram_addr  = alu;
  assign dbus.data_sram_wdata = wdata;

  assign lane = rdata_q >> {alu[1:0], 3'b000};
  assign half = alu[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = rdata_q;
    unique case (1'b1)
      ld_b:    load_data = {{24{lane[7]}}, lane[7:0]};
      ld_bu:   load_data = {24'd0, lane[7:0]};
      ld_h:    load_data = {{16{half[15]}}, half};
      ld_hu:   load_data = {16'd0, half};
      default: load_data = rdata_q;
    endcase
  end

  assign final_result = res_from_mem ? load_data : alu;

  assign front_valid = valid & gr_we
                     & (~res_from_mem | (state == DONE));
  assign front_addr  = waddr;
  assign front_data  = final_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_to_WB_reg  <= '0;
      MEM_except_reg <= '0;
    end else if (WB_allowin) begin
      if (readygo) begin
        MEM_to_WB_reg  <= {valid, pc, ir, gr_we, waddr, final_result};
        MEM_except_reg <= EX_except_reg;
      end else begin
        MEM_to_WB_reg  <= '0;
        MEM_except_reg <= '0;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage directly downstream of the execute stage. It consumes the execute stage's 145-bit pipeline register and 82-bit exception register. It issues loads and stores on a request/address-ok/data-ok data-SRAM interface, then aligns and extends load data. It forwards the result to decode for bypassing and registers the outcome into the MEM→WB pipeline register.

Parameters:
None. Field layouts are fixed by the pipeline zip formats below.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
WB_allowin  in  1  WB can accept an instruction this cycle
EX_to_MEM_zip  in  145  [144] valid, [143:112] pc, [111:80] IR, [79] ld_b, [78] ld_bu, [77] ld_h, [76] ld_hu, [75] ld_w, [74] st_b, [73] st_h, [72] st_w, [71] mem_we, [70] res_from_mem, [69] gr_we, [68:37] rkd_value, [36:32] rf_waddr, [31:0] alu_result (= memory address)
EX_except_reg  in  82  CSR/exception bundle; passed through untouched
MEM_allowin  out  1  to EX; = ~valid | readygo & WB_allowin
front_valid  out  1  bypass valid to decode
front_addr  out  5  bypass destination register = rf_waddr
front_data  out  32  bypass data = final_result
data_sram_req  out  1  memory request
data_sram_wr  out  1  1 = store; equals mem_we
data_sram_size  out  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  out  4  byte write strobes; 0 for loads
data_sram_addr  out  32  = alu_result
data_sram_wdata  out  32  replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response complete
data_sram_rdata  in  32  load data, valid with data_ok
MEM_to_WB_reg  out  103  {valid, pc, IR, gr_we, rf_waddr, final_result}
MEM_except_reg  out  82  registered copy of EX_except_reg

Behaviour:
- Decode: mem_op = ld_* | st_*. Inputs are held stable by EX while MEM_allowin=0.
- FSM with states IDLE, WAIT, DONE. Reset state is IDLE.
  - IDLE: data_sram_req = valid & mem_op & (state==IDLE). On req & addr_ok → WAIT. Otherwise stay, holding req high.
  - WAIT: req = 0. On data_ok → DONE; capture rdata into rdata_q (32-bit reg).
  - DONE: on WB_allowin → IDLE.
- data_ok is only sampled in WAIT. It is ignored in IDLE and DONE, including the addr_ok cycle itself.
- Exactly one outstanding transaction at a time.
- readygo = valid & (~mem_op | state==DONE). A non-memory instruction passes in zero extra cycles.
- Stores also wait for data_ok before readygo.
- Size encoding:
  - byte ops: size 0
  - half ops: size 1
  - ld_w / st_w: size 2
- Store data and strobes:
  - st_b: wdata = {4{rkd[7:0]}}, wstrb = 1<<addr[1:0]
  - st_h: wdata = {2{rkd[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011
  - st_w: wdata = rkd, wstrb = 4'b1111
- Load data, using rdata_q:
  - Byte lane is selected by addr[1:0]; half lane by addr[1]. addr[0] is ignored for half ops (no misalign exception in this stage).
  - ld_b / ld_h sign-extend; ld_bu / ld_hu zero-extend; ld_w passes through.
- final_result = res_from_mem ? load_data : alu_result.
- Bypass: front_valid = valid & gr_we & (~res_from_mem | state==DONE).
- Output registers:
  - On readygo & WB_allowin: MEM_to_WB_reg ← {valid, pc, IR, gr_we, rf_waddr, final_result} and MEM_except_reg ← EX_except_reg.
  - On ~readygo & WB_allowin: both are cleared (bubble).
  - Otherwise both hold.
- Reset: async, on rst=0.
  - State → IDLE, rdata_q=0, MEM_to_WB_reg=0, MEM_except_reg=0.
  - data_sram_req=0 while in reset.
  - A transaction in flight at reset is abandoned; any later data_ok arrives in IDLE and is ignored.
- Simultaneous DONE & WB_allowin: the same edge returns to IDLE and EX presents its next instruction. A back-to-back memory op issues req in the following cycle.

Test Plan:
- ALU op (add, gr_we=1, alu_result=0x1234), WB_allowin=1 → MEM_to_WB_reg.final_result=0x1234 one edge later; req never asserted; MEM_allowin=1 throughout.
- ld_b addr 0x1003, addr_ok immediate, data_ok 2 cycles later, rdata=0x80AA5500 → req 1 cycle; result 0xFFFFFF80. Repeat with ld_bu → 0x00000080.
- st_h addr 0x2002, rkd=0xDEADBEEF → wr=1, size=1, wstrb=1100, wdata=0xBEEFBEEF; stage completes only after data_ok.
- addr_ok held low 3 cycles → req stays high with stable addr; MEM_allowin=0; exactly one accepted request.
- ld_w completes while WB_allowin=0 for 4 cycles → state DONE; front_valid=1 with rdata; output reg unchanged until WB_allowin, then loads once.
- rst pulled low during WAIT, then data_ok pulsed after release → all outputs 0, state IDLE, stray data_ok ignored.
